// File: rtl/cs_decode_rr_sched.sv
// Round-robin scheduler sharing one 3-to-8 chip-select decoder between 8 requesters.
// Grants are bounded by MAX_HOLD and separated by GAP_CYCLES of disabled decoder.
//
// state | meaning
// IDLE  | decoder disabled, arbitrating among requests each cycle
// GRANT | decoder enabled on sel, gnt one-hot to the owner
// GAP   | decoder disabled, sel frozen, break-before-make spacing
module cs_decode_rr_sched #(
   parameter int MAX_HOLD   = 15,
   parameter int GAP_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       abort,
   output logic [2:0] sel,
   output logic       en_d,
   output logic       en_e_n,
   output logic       en_f_n,
   output logic [7:0] gnt,
   output logic       busy,
   output logic       timeout
);

   localparam int HOLD_W = $clog2(MAX_HOLD + 1);
   localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        sel_q, sel_d;
   logic [2:0]        ptr_q, ptr_d;
   logic [7:0]        gnt_q, gnt_d;
   logic              en_d_q, en_d_d;
   logic              en_e_n_q, en_e_n_d;
   logic              en_f_n_q, en_f_n_d;
   logic              busy_q, busy_d;
   logic              timeout_q, timeout_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;

   logic       win_found;
   logic [2:0] win_idx;
   logic [2:0] scan_idx;
   logic       hold_max;
   logic       rel;

   // First requester at or after ptr, wrapping mod 8 through the 3-bit add
   always_comb begin
      win_found = 1'b0;
      win_idx   = ptr_q;
      scan_idx  = ptr_q;
      for (int k = 0; k < 8; k++) begin
         scan_idx = ptr_q + 3'(k);
         if (!win_found && req[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   assign hold_max = (hold_cnt_q == HOLD_W'(MAX_HOLD));
   assign rel      = !req[sel_q] || abort || hold_max;

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      ptr_d      = ptr_q;
      gnt_d      = gnt_q;
      hold_cnt_d = hold_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      timeout_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (win_found && !abort) begin
               state_d    = GRANT;
               sel_d      = win_idx;
               gnt_d      = 8'b1 << win_idx;
               hold_cnt_d = HOLD_W'(1);
            end
         end
         GRANT: begin
            if (rel) begin
               state_d   = GAP;
               gnt_d     = 8'h00;
               ptr_d     = sel_q + 3'd1;
               gap_cnt_d = GAP_W'(1);
               // Only a pure hold-limit cut reports timeout; abort or drop take precedence
               timeout_d = hold_max && req[sel_q] && !abort;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         GAP: begin
            if (gap_cnt_q == GAP_W'(GAP_CYCLES)) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      en_d_d   = (state_d == GRANT);
      en_e_n_d = (state_d != GRANT);
      en_f_n_d = (state_d != GRANT);
      busy_d   = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         sel_q      <= 3'd0;
         ptr_q      <= 3'd0;
         gnt_q      <= 8'h00;
         en_d_q     <= 1'b0;
         en_e_n_q   <= 1'b1;
         en_f_n_q   <= 1'b1;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
         hold_cnt_q <= '0;
         gap_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         ptr_q      <= ptr_d;
         gnt_q      <= gnt_d;
         en_d_q     <= en_d_d;
         en_e_n_q   <= en_e_n_d;
         en_f_n_q   <= en_f_n_d;
         busy_q     <= busy_d;
         timeout_q  <= timeout_d;
         hold_cnt_q <= hold_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
      end
   end

   assign sel     = sel_q;
   assign en_d    = en_d_q;
   assign en_e_n  = en_e_n_q;
   assign en_f_n  = en_f_n_q;
   assign gnt     = gnt_q;
   assign busy    = busy_q;
   assign timeout = timeout_q;

endmodule
